mem_stage_ctrl: RTL and testbench

Memory-access stage controller placed directly downstream of the EX/MEM pipeline register and upstream of WB. It resolves branch/jump redirection, runs a request/acknowledge transaction with a variable-latency data memory for loads and stores, stalls the front of the pipeline while a transaction is outstanding, and holds the MEM/WB pipeline register feeding write-back.

---
 rtl/mem_stage_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//
// Memory-access stage controller. It sits between the EX/MEM and MEM/WB pipeline registers
// and does four things:
//   - resolves branch/jump redirection,
//   - runs a req/ack transaction with a variable-latency data memory,
//   - stalls the front of the pipeline while a transaction is outstanding,
//   - holds the MEM/WB register that feeds write-back.
//
// Parameters:
//   MAX_WAIT          wait cycles allowed after the issue cycle before an abort (1..255)
//
// Optional feature (compile-time macro):
//   MEM_MISALIGN_TRAP_EN  when defined, a load/store whose address is not word aligned is
//                         not issued. It sets mem_err and retires as a bubble.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   pc_plus_x_in .. reg_write_in      EX/MEM pipeline register contents
//   dmem_req/we/addr/wdata            request to data memory
//   dmem_ack/rdata                    completion and read data from data memory
//   stall                             freeze PC, IF/ID, ID/EX, EX/MEM
//   pc_src/pc_target                  redirect request (combinational)
//   wb_*                              MEM/WB pipeline register
//   mem_err                           sticky error (timeout or misalignment)

module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_plus_x_in,
    input  logic [31:0] alu_result_in,
    input  logic        zero_in,
    input  logic [31:0] read_data2_in,
    input  logic [4:0]  rd_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_rd,
    output logic        wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic        mem_err
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [4:0]  r_rd;
    logic        r_mem_to_reg;
    logic        r_reg_write;

    logic w_idle;
    logic w_mem_op;
    logic w_misalign;
    logic w_issue;
    logic w_timeout;

    always_comb begin
        w_idle   = (r_state == ST_IDLE);
        w_mem_op = mem_read_in | mem_write_in;
`ifdef MEM_MISALIGN_TRAP_EN
        w_misalign = w_mem_op & (alu_result_in[1:0] != 2'b00);
`else
        w_misalign = 1'b0;
`endif
        w_issue   = w_mem_op & ~w_misalign;
        // An ack in the same cycle as the limit wins, so the abort needs !dmem_ack.
        w_timeout = ~w_idle & ~dmem_ack & (r_cnt == MaxWait);

        dmem_req   = w_idle ? w_issue       : ~w_timeout;
        dmem_we    = w_idle ? mem_write_in  : r_we;
        dmem_addr  = w_idle ? alu_result_in : r_addr;
        dmem_wdata = w_idle ? read_data2_in : r_wdata;

        stall = w_idle ? (w_issue & ~dmem_ack) : (~dmem_ack & ~w_timeout);

        pc_src    = ((branch_in & zero_in) | jump_in) & w_idle;
        pc_target = pc_plus_x_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_we          <= 1'b0;
            r_rd          <= 5'd0;
            r_mem_to_reg  <= 1'b0;
            r_reg_write   <= 1'b0;
            wb_read_data  <= 32'd0;
            wb_alu_result <= 32'd0;
            wb_rd         <= 5'd0;
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            // Default MEM/WB load is a bubble; retiring paths override it below.
            wb_read_data  <= 32'd0;
            wb_alu_result <= 32'd0;
            wb_rd         <= 5'd0;
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_issue && !dmem_ack) begin
                        r_addr       <= alu_result_in;
                        r_wdata      <= read_data2_in;
                        r_we         <= mem_write_in;
                        r_rd         <= rd_in;
                        r_mem_to_reg <= mem_to_reg_in;
                        r_reg_write  <= reg_write_in;
                        r_cnt        <= 8'd0;
                        r_state      <= ST_WAIT;
                    end else if (w_misalign) begin
                        mem_err <= 1'b1;
                    end else begin
                        // Zero-wait completion or non-memory instruction. A stray ack
                        // without a read in flight contributes no data.
                        wb_alu_result <= alu_result_in;
                        wb_rd         <= rd_in;
                        wb_mem_to_reg <= mem_to_reg_in;
                        wb_reg_write  <= reg_write_in;
                        if (mem_read_in && !mem_write_in && dmem_ack) begin
                            wb_read_data <= dmem_rdata;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        wb_alu_result <= r_addr;
                        wb_rd         <= r_rd;
                        wb_mem_to_reg <= r_mem_to_reg;
                        wb_reg_write  <= r_reg_write;
                        if (!r_we) begin
                            wb_read_data <= dmem_rdata;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        mem_err <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl, built with MAX_WAIT = 4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled 1-2 units later,
// well away from the next edge.

module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_plus_x_in, alu_result_in, read_data2_in, dmem_rdata;
    logic        zero_in, branch_in, jump_in, mem_read_in, mem_write_in;
    logic        mem_to_reg_in, reg_write_in, dmem_ack;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we, stall, pc_src, wb_mem_to_reg, wb_reg_write, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, pc_target, wb_read_data, wb_alu_result;
    logic [4:0]  wb_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_plus_x_in(pc_plus_x_in), .alu_result_in(alu_result_in), .zero_in(zero_in),
        .read_data2_in(read_data2_in), .rd_in(rd_in),
        .branch_in(branch_in), .jump_in(jump_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        pc_plus_x_in = 32'd0; alu_result_in = 32'd0; read_data2_in = 32'd0;
        dmem_rdata = 32'd0; zero_in = 1'b0; branch_in = 1'b0; jump_in = 1'b0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
        reg_write_in = 1'b0; dmem_ack = 1'b0; rd_in = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
        clr_in();
        mem_read_in = 1'b1; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
        alu_result_in = addr; rd_in = rd;
    endtask

    initial begin
        // Reset
        clr_in();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_wb_read_data", wb_read_data, 32'd0);
        chk("rst_wb_alu_result", wb_alu_result, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pc_src", 32'(pc_src), 32'd0);

        // Zero-wait load
        tick();
        set_load(32'h100, 5'd5);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("zw_req", 32'(dmem_req), 32'd1);
        chk("zw_we", 32'(dmem_we), 32'd0);
        chk("zw_addr", dmem_addr, 32'h100);
        chk("zw_stall", 32'(stall), 32'd0);
        tick();
        chk("zw_wb_read_data", wb_read_data, 32'hDEADBEEF);
        chk("zw_wb_rd", 32'(wb_rd), 32'd5);
        chk("zw_wb_reg_write", 32'(wb_reg_write), 32'd1);
        chk("zw_wb_mem_to_reg", 32'(wb_mem_to_reg), 32'd1);
        chk("zw_wb_alu_result", wb_alu_result, 32'h100);

        // Store acked 3 cycles after issue
        clr_in();
        mem_write_in = 1'b1; alu_result_in = 32'h40; read_data2_in = 32'h12345678;
        #1;
        chk("st_issue_stall", 32'(stall), 32'd1);
        chk("st_issue_we", 32'(dmem_we), 32'd1);
        for (int i = 1; i <= 2; i++) begin
            tick();
            // Perturb the upstream fields: the latched copy must keep the bus stable.
            alu_result_in = 32'hFFFF0000; read_data2_in = 32'h0; mem_write_in = 1'b0;
            branch_in = 1'b1; zero_in = 1'b1;
            #1;
            chk("st_wait_stall", 32'(stall), 32'd1);
            chk("st_wait_addr", dmem_addr, 32'h40);
            chk("st_wait_wdata", dmem_wdata, 32'h12345678);
            chk("st_wait_we", 32'(dmem_we), 32'd1);
            chk("st_wait_pc_src", 32'(pc_src), 32'd0);
            chk("st_wait_wb_reg_write", 32'(wb_reg_write), 32'd0);
        end
        tick();
        clr_in();
        dmem_ack = 1'b1;
        #1;
        chk("st_ack_stall", 32'(stall), 32'd0);
        chk("st_ack_req", 32'(dmem_req), 32'd1);
        tick();
        dmem_ack = 1'b0;
        chk("st_done_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("st_done_wb_alu_result", wb_alu_result, 32'h40);
        chk("st_done_wb_read_data", wb_read_data, 32'd0);

        // Timeout: issue plus 4 stalled wait cycles, then abort
        set_load(32'h80, 5'd7);
        #1;
        chk("to_issue_stall", 32'(stall), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("to_wait_stall", 32'(stall), 32'd1);
            chk("to_wait_req", 32'(dmem_req), 32'd1);
        end
        tick();
        chk("to_abort_req", 32'(dmem_req), 32'd0);
        chk("to_abort_stall", 32'(stall), 32'd0);
        clr_in();
        tick();
        chk("to_mem_err", 32'(mem_err), 32'd1);
        chk("to_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("to_wb_rd", 32'(wb_rd), 32'd0);
        chk("to_req_idle", 32'(dmem_req), 32'd0);

        // Branch / jump redirect (IDLE)
        branch_in = 1'b1; zero_in = 1'b1; pc_plus_x_in = 32'h200;
        #1;
        chk("br_taken_pc_src", 32'(pc_src), 32'd1);
        chk("br_pc_target", pc_target, 32'h200);
        zero_in = 1'b0;
        #1;
        chk("br_not_taken_pc_src", 32'(pc_src), 32'd0);
        branch_in = 1'b0; jump_in = 1'b1;
        #1;
        chk("jmp_pc_src", 32'(pc_src), 32'd1);
        tick();
        chk("to_mem_err_sticky", 32'(mem_err), 32'd1);
        clr_in();

        // Non-memory ALU instruction
        alu_result_in = 32'h55; rd_in = 5'd3; reg_write_in = 1'b1;
        #1;
        chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_wb_alu_result", wb_alu_result, 32'h55);
        chk("alu_wb_rd", 32'(wb_rd), 32'd3);
        chk("alu_wb_reg_write", 32'(wb_reg_write), 32'd1);
        chk("alu_wb_read_data", wb_read_data, 32'd0);

        // Reset during WAIT (asserted in wait cycle 2)
        set_load(32'h180, 5'd4);
        tick();
        tick();
        chk("rw_wait_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        clr_in();
        tick();
        chk("rw_req", 32'(dmem_req), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        chk("rw_mem_err", 32'(mem_err), 32'd0);
        chk("rw_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rw_wb_alu_result", wb_alu_result, 32'd0);
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h11112222;
        #1;
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        tick();
        chk("late_ack_wb_read_data", wb_read_data, 32'd0);
        chk("late_ack_wb_reg_write", 32'(wb_reg_write), 32'd0);
        clr_in();

        // Ack in the same cycle the counter reaches MAX_WAIT wins
        set_load(32'h300, 5'd9);
        for (int i = 1; i <= 4; i++) begin
            tick();
        end
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("aw_req", 32'(dmem_req), 32'd1);
        chk("aw_stall", 32'(stall), 32'd0);
        tick();
        clr_in();
        chk("aw_wb_read_data", wb_read_data, 32'hCAFEF00D);
        chk("aw_wb_rd", 32'(wb_rd), 32'd9);
        chk("aw_wb_reg_write", 32'(wb_reg_write), 32'd1);
        chk("aw_mem_err", 32'(mem_err), 32'd0);

        // Misaligned load
        set_load(32'h102, 5'd6);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        tick();
        clr_in();
        chk("mis_mem_err", 32'(mem_err), 32'd1);
        chk("mis_wb_reg_write", 32'(wb_reg_write), 32'd0);
`else
        chk("mis_req", 32'(dmem_req), 32'd1);
        chk("mis_addr", dmem_addr, 32'h102);
        tick();
        clr_in();
        chk("mis_mem_err", 32'(mem_err), 32'd0);
        chk("mis_wb_read_data", wb_read_data, 32'h0BADF00D);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
